// File: rtl/rle_stream_pkg.sv
// Image tables and default widths for the RLE pixel streamer.
// Optional border overlay: RLE_STREAM_BORDER_EN.
package rle_stream_pkg;

  localparam int DEF_SEG_W = 8;
  localparam int DEF_RUN_W = 8;
  localparam int DEF_COL_W = 8;
  localparam int NUM_IMG   = 4;
  localparam int RLE_N     = 18;

  function automatic int img_len(int i);
    case (i)
      0: return 6;
      1: return 4;
      2: return 5;
      3: return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int img_width(int i);
    case (i)
      0: return 7;
      1: return 4;
      2: return 5;
      3: return 10;
      default: return 1;
    endcase
  endfunction

  function automatic logic img_start(int i);
    case (i)
      1, 2: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int img_base(int i);
    case (i)
      0: return 0;
      1: return 6;
      2: return 10;
      3: return 15;
      default: return 0;
    endcase
  endfunction

  // Flat run table; a zero run still emits one pixel
  function automatic int rle_at(int k);
    case (k)
      0: return 3;   1: return 2;   2: return 0;
      3: return 4;   4: return 6;   5: return 5;
      6: return 1;   7: return 7;   8: return 2;
      9: return 2;  10: return 4;  11: return 4;
      12: return 1; 13: return 3;  14: return 8;
      15: return 10; 16: return 1; 17: return 9;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/rle_image_streamer_if.sv
// Pixel stream bus: valid/ready handshake plus sync markers.
// Optional border overlay: RLE_STREAM_BORDER_EN.
interface rle_image_streamer_if;
  logic pix_valid;
  logic pix_ready;
  logic pix_data;
  logic h_sync;
  logic v_sync;
  logic frame_done;

  modport master (
    output pix_valid, pix_data,
    output h_sync, v_sync, frame_done,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_data,
    input  h_sync, v_sync, frame_done,
    output pix_ready
  );
endinterface

// File: rtl/rle_image_rom.sv
// Combinational image table lookup: run length and image geometry.
// Optional border overlay: RLE_STREAM_BORDER_EN.
module rle_image_rom
  import rle_stream_pkg::*;
#(
  parameter int IMG_W = 2,
  parameter int SEG_W = DEF_SEG_W,
  parameter int RUN_W = DEF_RUN_W,
  parameter int COL_W = DEF_COL_W
) (
  input  logic [IMG_W-1:0] img,
  input  logic [SEG_W-1:0] seg_idx,
  output logic [RUN_W-1:0] run_len,
  output logic [SEG_W-1:0] last_seg,
  output logic [COL_W-1:0] width_m1,
  output logic             start
);

  always_comb begin
    run_len  = RUN_W'(rle_at(img_base(int'(img))
                      + int'(seg_idx)));
    last_seg = SEG_W'(img_len(int'(img)) - 1);
    width_m1 = COL_W'(img_width(int'(img)) - 1);
    start    = img_start(int'(img));
  end

endmodule

// File: rtl/rle_image_streamer.sv
// Multi-image run-length-decoding 1-bit pixel streamer.
// Optional border overlay: RLE_STREAM_BORDER_EN.
module rle_image_streamer
  import rle_stream_pkg::*;
#(
  parameter int NUM_IMAGES = NUM_IMG,
  parameter int SEG_W      = DEF_SEG_W,
  parameter int RUN_W      = DEF_RUN_W,
  parameter int COL_W      = DEF_COL_W,
  parameter int IMG_W      =
    (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IMG_W-1:0]     img_sel,
  input  logic                 border_en,
  rle_image_streamer_if.master pix,
  output logic [IMG_W-1:0]     cur_img
);

  logic [SEG_W-1:0] seg_idx, last_seg;
  logic [RUN_W-1:0] run_cnt, run_len, run_last;
  logic [COL_W-1:0] col, width_m1;
  logic [IMG_W-1:0] nxt_img;
  logic             pix_state, started, done_q;
  logic             img_start_bit;
  logic             acc, run_end, seg_end, col_end;

  rle_image_rom #(
    .IMG_W (IMG_W),
    .SEG_W (SEG_W),
    .RUN_W (RUN_W),
    .COL_W (COL_W)
  ) u_rom (
    .img      (cur_img),
    .seg_idx  (seg_idx),
    .run_len  (run_len),
    .last_seg (last_seg),
    .width_m1 (width_m1),
    .start    (img_start_bit)
  );

  assign nxt_img  = (int'(img_sel) < NUM_IMAGES)
                  ? img_sel : '0;
  assign run_last = (run_len == '0) ? '0
                  : run_len - RUN_W'(1);
  assign run_end  = (run_cnt >= run_last);
  assign seg_end  = (seg_idx == last_seg);
  assign col_end  = (col == width_m1);
  assign acc      = started & pix.pix_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_idx   <= '0;
      run_cnt   <= '0;
      col       <= '0;
      cur_img   <= nxt_img;
      pix_state <= img_start(int'(nxt_img));
      started   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      started <= 1'b1;
      done_q  <= 1'b0;
      if (acc) begin
        col <= col_end ? '0 : col + COL_W'(1);
        if (!run_end) begin
          run_cnt <= run_cnt + RUN_W'(1);
        end else begin
          run_cnt   <= '0;
          pix_state <= ~pix_state;
          seg_idx   <= seg_idx + SEG_W'(1);
        end
        // Frame end: latch the next image and restart
        if (run_end && seg_end) begin
          seg_idx   <= '0;
          col       <= '0;
          done_q    <= 1'b1;
          cur_img   <= nxt_img;
          pix_state <= img_start(int'(nxt_img));
        end
      end
    end
  end

  assign pix.pix_valid  = started;
  assign pix.frame_done = done_q;
  assign pix.h_sync     = started & (col == '0);
  assign pix.v_sync     = started & (seg_idx == '0)
                        & (run_cnt == '0);

`ifdef RLE_STREAM_BORDER_EN
  assign pix.pix_data = pix_state
    | (border_en & ((col == '0) | col_end));
`else
  logic unused_border;
  assign unused_border = border_en;
  assign pix.pix_data  = pix_state;
`endif

  logic unused_start;
  assign unused_start = img_start_bit;

endmodule

// File: tb/tb_rle_image_streamer.sv
// Randomized bench for rle_image_streamer against a frame-level model.
// Optional border overlay: RLE_STREAM_BORDER_EN.
module tb_rle_image_streamer;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] img_sel = 2'd0;
  logic       border_en = 1'b1;
  logic       pix_ready = 1'b1;
  logic [1:0] cur_img;

  rle_image_streamer_if bus();
  assign bus.pix_ready = pix_ready;

  rle_image_streamer #(.NUM_IMAGES(NI)) dut (
    .clk       (clk),
    .reset     (reset),
    .img_sel   (img_sel),
    .border_en (border_en),
    .pix       (bus),
    .cur_img   (cur_img)
  );

  always #5 clk = ~clk;

  int T_RUN [4][6] = '{'{3, 2, 0, 4, 6, 5},
                       '{1, 7, 2, 2, 0, 0},
                       '{4, 4, 1, 3, 8, 0},
                       '{10, 1, 9, 0, 0, 0}};
  int T_LEN [4] = '{6, 4, 5, 3};
  int T_W   [4] = '{7, 4, 5, 10};
  int T_ST  [4] = '{0, 1, 1, 0};

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  function automatic int san(int s);
    return (s < NI) ? s : 0;
  endfunction

  int q_data[$];
  int q_col[$];
  int q_v[$];

  function automatic void load_frame(int img);
    int v, cnt, n;
    q_data.delete(); q_col.delete(); q_v.delete();
    v = T_ST[img];
    cnt = 0;
    for (int s = 0; s < T_LEN[img]; s++) begin
      n = (T_RUN[img][s] == 0) ? 1 : T_RUN[img][s];
      for (int j = 0; j < n; j++) begin
        q_data.push_back(v);
        q_col.push_back(cnt % T_W[img]);
        q_v.push_back(cnt == 0);
        cnt++;
      end
      v = 1 - v;
    end
  endfunction

  function automatic int frame_px(int img);
    int t = 0;
    for (int s = 0; s < T_LEN[img]; s++)
      t += (T_RUN[img][s] == 0) ? 1 : T_RUN[img][s];
    return t;
  endfunction

  bit armed = 0;
  int m_started = 0;
  int m_fd = 0;
  int m_img = 0;
  int acc_cnt = 0;
  int last_px = 0;

  always @(negedge clk) begin
    int d, c;
    if (armed) begin
      chk("pix_valid", int'(bus.pix_valid), m_started);
      chk("frame_done", int'(bus.frame_done), m_fd);
      chk("cur_img", int'(cur_img), m_img);
      if (m_started != 0) begin
        if (q_data.size() == 0) begin
          chk("model_empty", 0, 1);
        end else begin
          c = q_col[0];
          d = q_data[0];
`ifdef RLE_STREAM_BORDER_EN
          if (border_en && (c == 0 || c == T_W[m_img] - 1))
            d = 1;
`endif
          chk("pix_data", int'(bus.pix_data), d);
          chk("h_sync", int'(bus.h_sync), int'(c == 0));
          chk("v_sync", int'(bus.v_sync), q_v[0]);
        end
      end
    end
    if (reset) begin
      armed = 1;
      m_started = 0;
      m_fd = 0;
      m_img = san(int'(img_sel));
      acc_cnt = 0;
      load_frame(m_img);
    end else if (armed) begin
      m_fd = 0;
      if (m_started != 0 && pix_ready && q_data.size() > 0) begin
        void'(q_data.pop_front());
        void'(q_col.pop_front());
        void'(q_v.pop_front());
        acc_cnt++;
        if (q_data.size() == 0) begin
          m_fd = 1;
          last_px = acc_cnt;
          acc_cnt = 0;
          m_img = san(int'(img_sel));
          load_frame(m_img);
        end
      end
      m_started = 1;
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic to_frame_done(bit rnd, int limit);
    bit seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(posedge clk);
      #1;
      if (bus.frame_done) seen = 1;
      else if (rnd) pix_ready = 1'($urandom_range(0, 1));
    end
    chk("frame_done_seen", int'(seen), 1);
  endtask

  initial begin
    chk("model_len0", frame_px(0), 21);
    chk("model_len2", frame_px(2), 20);

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("valid_at_drop", int'(bus.pix_valid), 0);
    step(1);
    chk("first_valid", int'(bus.pix_valid), 1);
    chk("first_vsync", int'(bus.v_sync), 1);
    chk("first_hsync", int'(bus.h_sync), 1);
`ifdef RLE_STREAM_BORDER_EN
    chk("first_data", int'(bus.pix_data), 1);
`else
    chk("first_data", int'(bus.pix_data), 0);
`endif

    to_frame_done(0, 200);
    chk("img0_pixels", last_px, 21);
    chk("next_vsync", int'(bus.v_sync), 1);
    chk("cur_img_0", int'(cur_img), 0);
    step(1);
    chk("fd_pulse", int'(bus.frame_done), 0);

    to_frame_done(1, 400);
    chk("img0_rand_px", last_px, 21);

    pix_ready = 1'b1;
    step(5);
    img_sel = 2'd2;
    step(3);
    chk("hold_img", int'(cur_img), 0);
    to_frame_done(1, 400);
    chk("switch_img2", int'(cur_img), 2);

    step(4);
    img_sel = 2'd3;
    to_frame_done(1, 400);
    chk("img2_pixels", last_px, 20);
    chk("oob_img", int'(cur_img), 0);

    pix_ready = 1'b1;
    img_sel = 2'd1;
    step(7);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("rst_valid", int'(bus.pix_valid), 0);
    chk("rst_img", int'(cur_img), 1);
    step(1);
    chk("rst_vsync", int'(bus.v_sync), 1);
    chk("rst_hsync", int'(bus.h_sync), 1);
    chk("rst_data", int'(bus.pix_data), 1);
    to_frame_done(1, 400);
    chk("img1_pixels", last_px, 12);

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
